prga_decrypt: RTL
=================

Name: prga_decrypt

Overview:
- Third loop of the RC4 key-search datapath. It runs the RC4 PRGA over the key-scheduled S memory and XORs the keystream with the encrypted ROM, one character at a time.
- It is the producer side of the character handshake. It presents each decrypted byte with a `new_char` pulse, then waits for the character checker to accept the byte (`compared_char`) or abort the key (`start_over`).
- Decrypted bytes are also written to the result RAM.

Parameters:
- MSG_LEN, 32, number of message characters; k runs 0..MSG_LEN-1.
- K_W, 6, width of k / char_count; must satisfy 2^K_W > MSG_LEN.

Ports:
- clk  in  1  system clock
- resetm  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse from the KSA loop; begins decryption with the current S
- s_addr  out  8  S RAM address
- s_wrdata  out  8  S RAM write data
- s_wren  out  1  S RAM write enable
- s_rddata  in  8  S RAM read data
- rom_addr  out  K_W  encrypted ROM address
- rom_rddata  in  8  encrypted ROM data
- d_addr  out  K_W  result RAM address
- d_wrdata  out  8  result RAM write data
- d_wren  out  1  result RAM write enable
- char_out  out  8  decrypted character; held stable from the EMIT state through the ACK state
- new_char  out  1  one-cycle pulse: char_out is valid
- char_count  out  K_W  current k
- compared_char  in  1  checker accepted the character
- start_over  in  1  checker rejected the character; abandon the current key
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  level; all MSG_LEN characters accepted

Behaviour:
- Reset: resetm=0 forces the IDLE state asynchronously, and every output, plus the internal i, j, si, sj and f registers, to 0.
- All outputs are registered.
- Memory timing: S and ROM are synchronous, single-port memories. Read data is sampled exactly two edges after the edge that loads the address, which is why each read has one WT state.
- Width rules: i, j and all S-index sums are 8-bit and wrap mod 256, with no carry out. k is K_W bits.
- State machine; every state lasts one cycle unless noted:
  - IDLE: on start, clear i, j and k, go to RD_I. Otherwise stay.
  - RD_I: i<=i+1; s_addr<=i+1.
  - WT_I.
  - CP_I: si<=s_rddata; j<=j+s_rddata; s_addr<=j+s_rddata.
  - WT_J.
  - CP_J: sj<=s_rddata; s_addr<=i; s_wrdata<=s_rddata; s_wren<=1.
  - WR_J: s_addr<=j; s_wrdata<=si; s_wren<=1.
  - RD_F: s_wren<=0; s_addr<=si+sj; rom_addr<=k.
  - WT_F.
  - XOR: char_out<=s_rddata^rom_rddata; d_addr<=k; d_wrdata<=same value; d_wren<=1.
  - EMIT: d_wren<=0; new_char<=1.
  - ACK (multi-cycle): new_char<=0.
    - start_over=1: go to IDLE; k and done unchanged, no further S writes.
    - else compared_char=1: k<=k+1; if k==MSG_LEN-1 go to DONE, else RD_I.
    - else stay in ACK.
  - DONE (multi-cycle): done<=1; char_count=MSG_LEN. Stay until start, then clear done and behave as IDLE+start.
- Latency: 10 cycles from the edge leaving IDLE, or from ACK acceptance, to new_char high.
- Boundary conditions:
  - compared_char and start_over both high: start_over wins.
  - Handshake inputs outside ACK are ignored. A compared_char pulse arriving before EMIT is not remembered.
  - start while busy is ignored. start_over outside ACK is ignored.
  - i=255 wraps to 0 on increment.
  - Reset mid-operation abandons the in-flight S swap. A partially written S is not repaired; the KSA loop rebuilds S.

Optional Feature:
- PRGA_SKIP_DRAM_EN
- Defined: d_wren, d_addr and d_wrdata are tied to 0 and the XOR state writes nothing. Used for fast key search where the result RAM is unused.
- Undefined: result RAM writes as described in Behaviour.

Test Plan:
- S identity (s[x]=x), ROM all 0x00, start pulse → first new_char 10 cycles later with char_out=0x02, d_addr=0, d_wrdata=0x02, s[1] unchanged.
- Same setup, ack first char with compared_char → second char_out=0x05, S now has s[2]=0x03 and s[3]=0x02, char_count=1.
- ROM[0]=0x63, identity S → char_out=0x61 ('a'). Hold compared_char low for 20 cycles → new_char pulses exactly once, char_out stable.
- In ACK for k=5, pulse start_over → returns to IDLE with char_count=5, done=0, no S writes, no new_char. A new start pulse restarts at k=0.
- Ack all 32 characters → done=1 after the 32nd ack, char_count=32, busy=0. Raise compared_char and start_over together on k=0 → abort, done=0.
- resetm low during WR_J → all outputs 0 immediately (asynchronous), state IDLE. Then build with PRGA_SKIP_DRAM_EN → d_wren never asserted over a full run.

Source files
------------

// File: rtl/prga_decrypt.sv
// RC4 PRGA loop: swaps S, XORs the keystream with the encrypted ROM and hands each byte to the checker.
// Define PRGA_SKIP_DRAM_EN to remove the result-RAM write port (d_* outputs tied to 0).
module prga_decrypt #(
  parameter int MSG_LEN = 32,
  parameter int K_W     = 6
) (
  input  logic           clk,
  input  logic           resetm,
  input  logic           start,
  output logic [7:0]     s_addr,
  output logic [7:0]     s_wrdata,
  output logic           s_wren,
  input  logic [7:0]     s_rddata,
  output logic [K_W-1:0] rom_addr,
  input  logic [7:0]     rom_rddata,
  output logic [K_W-1:0] d_addr,
  output logic [7:0]     d_wrdata,
  output logic           d_wren,
  output logic [7:0]     char_out,
  output logic           new_char,
  output logic [K_W-1:0] char_count,
  input  logic           compared_char,
  input  logic           start_over,
  output logic           busy,
  output logic           done
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_I, S_WT_I, S_CP_I, S_WT_J, S_CP_J, S_WR_J,
    S_RD_F, S_WT_F, S_XOR, S_EMIT, S_ACK, S_DONE
  } state_t;

  localparam logic [K_W-1:0] K_LAST = K_W'(MSG_LEN - 1);

  state_t         state_q, state_d;
  logic [7:0]     i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [K_W-1:0] k_q, k_d;
  logic [7:0]     s_addr_q, s_addr_d, s_wrdata_q, s_wrdata_d;
  logic           s_wren_q, s_wren_d;
  logic [K_W-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]     char_q, char_d;
  logic           new_char_q, new_char_d;
  logic           busy_q, busy_d, done_q, done_d;
`ifndef PRGA_SKIP_DRAM_EN
  logic [K_W-1:0] d_addr_q, d_addr_d;
  logic [7:0]     d_wrdata_q, d_wrdata_d;
  logic           d_wren_q, d_wren_d;
`endif

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    si_d       = si_q;
    sj_d       = sj_q;
    k_d        = k_q;
    s_addr_d   = s_addr_q;
    s_wrdata_d = s_wrdata_q;
    s_wren_d   = s_wren_q;
    rom_addr_d = rom_addr_q;
    char_d     = char_q;
    new_char_d = new_char_q;
    done_d     = done_q;
`ifndef PRGA_SKIP_DRAM_EN
    d_addr_d   = d_addr_q;
    d_wrdata_d = d_wrdata_q;
    d_wren_d   = d_wren_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          i_d     = 8'd0;
          j_d     = 8'd0;
          k_d     = '0;
          state_d = S_RD_I;
        end
      end
      S_RD_I: begin
        i_d      = i_q + 8'd1;
        s_addr_d = i_q + 8'd1;
        state_d  = S_WT_I;
      end
      S_WT_I: state_d = S_CP_I;
      S_CP_I: begin
        si_d     = s_rddata;
        j_d      = j_q + s_rddata;
        s_addr_d = j_q + s_rddata;
        state_d  = S_WT_J;
      end
      S_WT_J: state_d = S_CP_J;
      // Swap is two back-to-back writes: S[i] <= S[j], then S[j] <= S[i].
      S_CP_J: begin
        sj_d       = s_rddata;
        s_addr_d   = i_q;
        s_wrdata_d = s_rddata;
        s_wren_d   = 1'b1;
        state_d    = S_WR_J;
      end
      S_WR_J: begin
        s_addr_d   = j_q;
        s_wrdata_d = si_q;
        s_wren_d   = 1'b1;
        state_d    = S_RD_F;
      end
      S_RD_F: begin
        s_wren_d   = 1'b0;
        s_addr_d   = si_q + sj_q;
        rom_addr_d = k_q;
        state_d    = S_WT_F;
      end
      S_WT_F: state_d = S_XOR;
      S_XOR: begin
        char_d = s_rddata ^ rom_rddata;
`ifndef PRGA_SKIP_DRAM_EN
        d_addr_d   = k_q;
        d_wrdata_d = s_rddata ^ rom_rddata;
        d_wren_d   = 1'b1;
`endif
        state_d = S_EMIT;
      end
      S_EMIT: begin
`ifndef PRGA_SKIP_DRAM_EN
        d_wren_d = 1'b0;
`endif
        new_char_d = 1'b1;
        state_d    = S_ACK;
      end
      S_ACK: begin
        new_char_d = 1'b0;
        if (start_over) begin
          state_d = S_IDLE;
        end else if (compared_char) begin
          k_d     = k_q + K_W'(1);
          state_d = (k_q == K_LAST) ? S_DONE : S_RD_I;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        if (start) begin
          done_d  = 1'b0;
          i_d     = 8'd0;
          j_d     = 8'd0;
          k_d     = '0;
          state_d = S_RD_I;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clk or negedge resetm) begin
    if (!resetm) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      si_q       <= '0;
      sj_q       <= '0;
      k_q        <= '0;
      s_addr_q   <= '0;
      s_wrdata_q <= '0;
      s_wren_q   <= 1'b0;
      rom_addr_q <= '0;
      char_q     <= '0;
      new_char_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifndef PRGA_SKIP_DRAM_EN
      d_addr_q   <= '0;
      d_wrdata_q <= '0;
      d_wren_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      k_q        <= k_d;
      s_addr_q   <= s_addr_d;
      s_wrdata_q <= s_wrdata_d;
      s_wren_q   <= s_wren_d;
      rom_addr_q <= rom_addr_d;
      char_q     <= char_d;
      new_char_q <= new_char_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifndef PRGA_SKIP_DRAM_EN
      d_addr_q   <= d_addr_d;
      d_wrdata_q <= d_wrdata_d;
      d_wren_q   <= d_wren_d;
`endif
    end
  end

  assign s_addr     = s_addr_q;
  assign s_wrdata   = s_wrdata_q;
  assign s_wren     = s_wren_q;
  assign rom_addr   = rom_addr_q;
  assign char_out   = char_q;
  assign new_char   = new_char_q;
  assign char_count = k_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifndef PRGA_SKIP_DRAM_EN
  assign d_addr     = d_addr_q;
  assign d_wrdata   = d_wrdata_q;
  assign d_wren     = d_wren_q;
`else
  assign d_addr     = '0;
  assign d_wrdata   = '0;
  assign d_wren     = 1'b0;
`endif

endmodule
